// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller of the 9-bit-ISA core.
// Optional feature macro: RUN_CTRL_STEP_EN (single-step gating of RUN cycles).
package run_ctrl_pkg;

  // Controller state, also exported on the debug port of run_ctrl.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    TOUT  = 3'd4
  } run_state_t;

  // Opcode that the instruction decoder maps onto halt_instr.
  localparam logic [2:0] HALT_OPCODE = 3'b111;

endpackage

// File: rtl/run_ctrl_edge_det.sv
// Registered rise/fall detector. The input is sampled once per clock and
// compared against its previous sample; rise/fall are combinational pulses
// that are valid for the cycle in which the new level is first seen.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  // Previous-cycle sample of d.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/run_ctrl.sv
// Program sequencing and run controller: owns the PC, resolves branches,
// detects halt / self-loop termination and trips a cycle-budget watchdog.
// Optional feature macro: RUN_CTRL_STEP_EN adds a 'step' input; RUN cycles
// then advance only when step=1.
//
// Handshake: the host raises start (level) to arm the controller and drops it
// to launch the program. A rising edge of start in any state aborts and
// re-arms (pc and cycle_count cleared). done / timeout are sticky levels that
// stay asserted until the next start rising edge; pc and cycle_count hold
// their final values for inspection while they are high.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int PC_W    = 7,
  parameter int CYC_W   = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_instr,
  input  logic             branch,
  input  logic             branch_cond,
  input  logic             zero,
  input  logic [PC_W-1:0]  target,
`ifdef RUN_CTRL_STEP_EN
  input  logic             step,
`endif
  output logic [PC_W-1:0]  pc,
  output logic             run,
  output logic             done,
  output logic             timeout,
  output logic [CYC_W-1:0] cycle_count,
  output run_state_t       state_dbg
);

  run_state_t       state, state_n;
  logic [PC_W-1:0]  pc_n;
  logic [CYC_W-1:0] cyc_n;
  logic             start_rise, start_fall;
  logic             adv;
  logic             taken;
  logic             self_loop;
  logic             wd_trip;
  logic [PC_W-1:0]  next_pc;
  logic             run_n;

  edge_det u_start_edge (
    .clk   (clk),
    .reset (reset),
    .d     (start),
    .rise  (start_rise),
    .fall  (start_fall)
  );

`ifdef RUN_CTRL_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  // Branch resolution and termination conditions for the instruction at pc.
  always_comb begin
    taken     = branch & (~branch_cond | zero);
    next_pc   = taken ? target : pc + PC_W'(1);
    self_loop = taken && (target == pc);
    wd_trip   = (cycle_count == CYC_W'(TIMEOUT - 1));
  end

  // Next state, pc and counter. run is high only on cycles that actually
  // advance, so a terminating instruction (halt, self-loop, watchdog trip or
  // abort) never commits.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cyc_n   = cycle_count;
    run_n   = 1'b0;
    if (start_rise) begin
      state_n = ARMED;
      pc_n    = '0;
      cyc_n   = '0;
    end else begin
      case (state)
        ARMED: if (start_fall) state_n = RUN;
        RUN: begin
          if (adv) begin
            if (halt_instr)     state_n = DONE;
            else if (self_loop) state_n = DONE;
            else if (wd_trip)   state_n = TOUT;
            else begin
              pc_n  = next_pc;
              cyc_n = cycle_count + CYC_W'(1);
              run_n = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, pc and cycle counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      cycle_count <= cyc_n;
    end
  end

  assign run       = run_n;
  assign done      = (state == DONE);
  assign timeout   = (state == TOUT);
  assign state_dbg = state;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: a per-cycle vector table for the straight-line,
// branch and self-loop programs, then hand-written sequences for watchdog,
// halt/trip collision, abort, held start and asynchronous reset.
module tb_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int PC_W    = 7;
  localparam int CYC_W   = 10;
  localparam int TIMEOUT = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, halt_instr, branch, branch_cond, zero;
  logic [PC_W-1:0]  target;
  logic             step;
  logic [PC_W-1:0]  pc;
  logic             run, done, timeout;
  logic [CYC_W-1:0] cycle_count;
  run_state_t       state_dbg;

  int errors = 0;
  int checks = 0;

  run_ctrl #(.PC_W(PC_W), .CYC_W(CYC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .halt_instr  (halt_instr),
    .branch      (branch),
    .branch_cond (branch_cond),
    .zero        (zero),
    .target      (target),
`ifdef RUN_CTRL_STEP_EN
    .step        (step),
`endif
    .pc          (pc),
    .run         (run),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count),
    .state_dbg   (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #200000;
    $display("FAIL time_limit: bench did not finish, got running want finished");
    $fatal(1);
  end

  typedef struct {
    logic            st, hl, br, bc, z;
    logic [PC_W-1:0] tg;
    logic [PC_W-1:0] e_pc;
    logic            e_run, e_done, e_to;
    logic [CYC_W-1:0] e_cc;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input int e_pc, input int e_run,
                          input int e_done, input int e_to, input int e_cc);
    chk({tag, ".pc"},      32'(pc),          e_pc);
    chk({tag, ".run"},     32'(run),         e_run);
    chk({tag, ".done"},    32'(done),        e_done);
    chk({tag, ".timeout"}, 32'(timeout),     e_to);
    chk({tag, ".cycles"},  32'(cycle_count), e_cc);
  endtask

  task automatic set_in(input logic st, input logic hl, input logic br,
                        input logic bc, input logic z, input logic [PC_W-1:0] tg);
    start = st; halt_instr = hl; branch = br; branch_cond = bc; zero = z; target = tg;
  endtask

  // Leaves the bench just after the negedge of RUN cycle 0.
  task automatic launch();
    @(negedge clk); set_in(1, 0, 0, 0, 0, 0);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    step = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk_outs("reset", 0, 0, 0, 0, 0);
    chk("reset.state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk); reset = 1'b1;

    // st hl br bc z tg | pc run done to cc
    vq.push_back('{1,0,0,0,0,0,  0,0,0,0,0});   // rise -> ARMED
    vq.push_back('{1,0,0,0,0,0,  0,0,0,0,0});
    vq.push_back('{1,0,0,0,0,0,  0,0,0,0,0});
    vq.push_back('{0,0,0,0,0,0,  0,0,0,0,0});   // fall -> RUN
    vq.push_back('{0,0,0,0,0,0,  0,1,0,0,0});
    vq.push_back('{0,0,0,0,0,0,  1,1,0,0,1});
    vq.push_back('{0,0,0,0,0,0,  2,1,0,0,2});
    vq.push_back('{0,0,0,0,0,0,  3,1,0,0,3});
    vq.push_back('{0,0,0,0,0,0,  4,1,0,0,4});
    vq.push_back('{0,1,0,0,0,0,  5,0,0,0,5});   // halt at pc 5
    vq.push_back('{0,0,0,0,0,0,  5,0,1,0,5});
    vq.push_back('{0,1,0,0,0,0,  5,0,1,0,5});   // sticky
    vq.push_back('{1,0,0,0,0,0,  5,0,1,0,5});   // re-arm
    vq.push_back('{0,0,0,0,0,0,  0,0,0,0,0});
    vq.push_back('{0,0,0,0,0,0,  0,1,0,0,0});
    vq.push_back('{0,0,0,0,0,0,  1,1,0,0,1});
    vq.push_back('{0,0,1,1,0,6,  2,1,0,0,2});   // cond, zero=0: not taken
    vq.push_back('{0,0,1,0,0,2,  3,1,0,0,3});   // uncond, zero=0: taken
    vq.push_back('{0,0,1,1,1,6,  2,1,0,0,4});   // cond, zero=1: taken
    vq.push_back('{0,0,1,1,0,6,  6,1,0,0,5});   // target==pc but not taken
    vq.push_back('{0,0,1,0,1,9,  7,1,0,0,6});
    vq.push_back('{0,0,1,0,0,9,  9,0,0,0,7});   // self-loop at pc 9
    vq.push_back('{0,0,0,0,0,0,  9,0,1,0,7});

    foreach (vq[i]) begin
      @(negedge clk);
      set_in(vq[i].st, vq[i].hl, vq[i].br, vq[i].bc, vq[i].z, vq[i].tg);
      #1;
      chk_outs($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_run, vq[i].e_done,
               vq[i].e_to, vq[i].e_cc);
    end

    // Watchdog: 20 RUN cycles, with a wrap via target 127 at pc 2.
    launch();
    for (int i = 0; i < TIMEOUT; i++) begin
      set_in(0, 0, (i == 2), 0, 0, 7'd127);
      #1;
      chk_outs($sformatf("wd%0d", i), (i <= 2) ? i : ((i == 3) ? 127 : i - 4),
               (i != TIMEOUT - 1), 0, 0, i);
      @(negedge clk);
    end
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk_outs("wd_trip", 15, 0, 0, 1, 19);
    @(negedge clk); #1;
    chk_outs("wd_sticky", 15, 0, 0, 1, 19);

    // Halt in the same cycle as the watchdog trip: DONE wins.
    launch();
    for (int i = 0; i < TIMEOUT; i++) begin
      set_in(0, (i == TIMEOUT - 1), 0, 0, 0, 0);
      #1;
      chk_outs($sformatf("ht%0d", i), i, (i != TIMEOUT - 1), 0, 0, i);
      @(negedge clk);
    end
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk_outs("halt_vs_wd", 19, 0, 1, 0, 19);

    // Abort at RUN cycle 7, then hold start high.
    launch();
    for (int i = 0; i < 7; i++) begin
      #1; chk_outs($sformatf("ab%0d", i), i, 1, 0, 0, i);
      @(negedge clk);
    end
    start = 1'b1;
    #1;
    chk_outs("abort_cycle", 7, 0, 0, 0, 7);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      chk_outs($sformatf("hold%0d", i), 0, 0, 0, 0, 0);
      chk($sformatf("hold%0d.state", i), 32'(state_dbg), 32'(ARMED));
    end
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1; chk_outs($sformatf("rr%0d", i), i, 1, 0, 0, i);
      @(negedge clk);
    end

    // Asynchronous reset mid-RUN, checked before the next rising edge.
    #1;
    chk_outs("pre_reset", 3, 1, 0, 0, 3);
    reset = 1'b0;
    #1;
    chk_outs("async_reset", 0, 0, 0, 0, 0);
    chk("async_reset.state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    chk_outs("post_reset", 0, 0, 0, 0, 0);

`ifdef RUN_CTRL_STEP_EN
    // Step every 4th cycle; halt presented at pc 2 is taken only on a step.
    begin
      int  exp_pc;
      logic hit;
      exp_pc = 0;
      hit    = 1'b0;
      launch();
      for (int k = 0; k < 16; k++) begin
        step       = ((k % 4) == 3);
        halt_instr = (exp_pc == 2);
        #1;
        chk_outs($sformatf("step%0d", k), exp_pc, (step && !halt_instr), 0, 0, exp_pc);
        @(negedge clk);
        if (step) begin
          if (halt_instr) begin
            hit = 1'b1;
            break;
          end
          exp_pc++;
        end
      end
      step = 1'b1;
      halt_instr = 1'b0;
      chk("step_halt_seen", 32'(hit), 1);
      #1;
      chk_outs("step_done", 2, 0, 1, 0, 2);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
